// File: rtl/spa_pkg.sv
// Shared definitions for the shortest-path unit: graph sizing, the distance
// sentinel, the FSM state encoding and the fixed 8-node edge-weight table.
package spa_pkg;

  localparam int NUM_NODES = 8;
  localparam int NODE_W    = 3;
  localparam int WEIGHT_W  = 4;
  localparam int DIST_W    = 8;

  localparam logic [DIST_W-1:0] INF = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SELECT,
    ST_RELAX,
    ST_TRACE,
    ST_STEP,
    ST_NOPATH
  } state_e;

  // Undirected graph: the pair is ordered (lo,hi) so one table entry serves
  // both directions. Weight 0 means no edge. Octal keys read as "lo hi".
  function automatic logic [WEIGHT_W-1:0] weight(input logic [NODE_W-1:0] a,
                                                 input logic [NODE_W-1:0] b);
    logic [NODE_W-1:0] lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    case ({lo, hi})
      6'o01:   return 4'd2;
      6'o12:   return 4'd2;
      6'o27:   return 4'd3;
      6'o03:   return 4'd1;
      6'o34:   return 4'd1;
      6'o45:   return 4'd5;
      6'o57:   return 4'd1;
      6'o46:   return 4'd2;
      6'o67:   return 4'd6;
      6'o15:   return 4'd7;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-FF synchronizer followed by a stability
// counter. The level follows the synchronized input only after it has
// disagreed for DEBOUNCE_CYCLES consecutive clocks; rise_o is a registered
// one-cycle pulse on the accepted rising edge.
// Ports: clk_i, rst_ni (async low), btn_i (raw), level_o, rise_o.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          lvl_q, lvl_d;
  logic          rise_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter restarts whenever the synchronized value agrees with the level,
  // so a glitch shorter than DEBOUNCE_CYCLES never reaches the output.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) lvl_d = sync_q[1];
      else                                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      lvl_q  <= lvl_d;
      rise_q <= lvl_d & ~lvl_q;
      cnt_q  <= cnt_d;
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/shortest_path_unit.sv
// Pushbutton-driven Dijkstra engine over the fixed 8-node graph in spa_pkg.
// Ports: clock, reset (async low), btn[3:0] = {soft_rst, start, tk_inp,
// io_sel} raw, pts (node from switches), led (path valid), out (shown node).
// The path stack is filled dst-first while walking prev[], so the source sits
// at the top; stepping pops toward dst and saturates at the bottom.
module shortest_path_unit
  import spa_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        btn,
  input  logic [NODE_W-1:0] pts,
  output logic              led,
  output logic [NODE_W-1:0] out
);

  logic [3:0] btn_lvl, btn_rise;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [3:0] (
    .clk_i  (clock),
    .rst_ni (reset),
    .btn_i  (btn),
    .level_o(btn_lvl),
    .rise_o (btn_rise)
  );

  logic io_sel, tk_pulse, start_pulse, srst_pulse;
  assign io_sel      = btn_lvl[0];
  assign tk_pulse    = btn_rise[1];
  assign start_pulse = btn_rise[2];
  assign srst_pulse  = btn_rise[3];

  logic unused_btn;
  assign unused_btn = ^{btn_lvl[3:1], btn_rise[0]};

  state_e                         state_q, state_d;
  logic [NODE_W-1:0]              src_q, dst_q;
  logic [NUM_NODES-1:0][DIST_W-1:0] dist_q;
  logic [NUM_NODES-1:0][NODE_W-1:0] prev_q;
  logic [NUM_NODES-1:0][NODE_W-1:0] path_q;
  logic [NUM_NODES-1:0]           visited_q;
  logic [NODE_W-1:0]              cur_q, nbr_q, tr_q, sp_q;
  logic [NODE_W:0]                len_q;
  logic [NODE_W-1:0]              out_q;
  logic                           led_q;

  // Minimum unvisited finite distance; strict compare keeps the lowest index
  // on ties. found=0 covers both "all visited" and "rest unreachable".
  logic [DIST_W-1:0] best;
  logic [NODE_W-1:0] sel;
  logic              found;
  always_comb begin
    best  = INF;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_NODES; i++) begin
      if (!visited_q[i] && dist_q[i] < best) begin
        best  = dist_q[i];
        sel   = NODE_W'(i);
        found = 1'b1;
      end
    end
  end

  logic [WEIGHT_W-1:0] w;
  logic [DIST_W-1:0]   cand;
  logic                upd;
  always_comb begin
    w    = weight(cur_q, nbr_q);
    cand = dist_q[cur_q] + DIST_W'(w);
    upd  = (w != '0) && !visited_q[nbr_q] && (cand < dist_q[nbr_q]);
  end

  // The source is the only reached node whose prev points at itself.
  logic tr_root, no_path;
  assign tr_root = (prev_q[tr_q] == tr_q);
  assign no_path = (len_q == '0) && (dist_q[tr_q] == INF);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_pulse) state_d = ST_INIT;
      ST_INIT:   state_d = ST_SELECT;
      ST_SELECT: state_d = found ? ST_RELAX : ST_TRACE;
      ST_RELAX:  if (nbr_q == NODE_W'(NUM_NODES - 1)) state_d = ST_SELECT;
      ST_TRACE: begin
        if (no_path)      state_d = ST_NOPATH;
        else if (tr_root) state_d = ST_STEP;
      end
      default:   state_d = state_q;
    endcase
    if (srst_pulse) state_d = ST_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Node entry is independent of the FSM so it still latches alongside a
  // soft reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      src_q <= '0;
      dst_q <= '0;
    end else if (tk_pulse) begin
      if (io_sel) dst_q <= pts;
      else        src_q <= pts;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dist_q    <= '{default: INF};
      prev_q    <= '0;
      path_q    <= '0;
      visited_q <= '0;
      cur_q     <= '0;
      nbr_q     <= '0;
      tr_q      <= '0;
      sp_q      <= '0;
      len_q     <= '0;
      out_q     <= '0;
      led_q     <= 1'b0;
    end else if (srst_pulse) begin
      out_q <= '0;
      led_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          for (int i = 0; i < NUM_NODES; i++) begin
            dist_q[i] <= (NODE_W'(i) == src_q) ? '0 : INF;
            prev_q[i] <= NODE_W'(i);
          end
          visited_q <= '0;
        end
        ST_SELECT: begin
          if (found) begin
            visited_q[sel] <= 1'b1;
            cur_q          <= sel;
            nbr_q          <= '0;
          end else begin
            tr_q  <= dst_q;
            len_q <= '0;
          end
        end
        ST_RELAX: begin
          if (upd) begin
            dist_q[nbr_q] <= cand;
            prev_q[nbr_q] <= cur_q;
          end
          nbr_q <= nbr_q + 1'b1;
        end
        ST_TRACE: begin
          if (no_path) begin
            out_q <= tr_q;
            led_q <= 1'b0;
          end else begin
            path_q[len_q[NODE_W-1:0]] <= tr_q;
            len_q                     <= len_q + 1'b1;
            if (tr_root) begin
              sp_q  <= len_q[NODE_W-1:0];
              out_q <= tr_q;
              led_q <= 1'b1;
            end else begin
              tr_q <= prev_q[tr_q];
            end
          end
        end
        ST_STEP: begin
          if (start_pulse && sp_q != '0) begin
            sp_q  <= sp_q - 1'b1;
            out_q <= path_q[sp_q - 1'b1];
          end
        end
        default: ;
      endcase
    end
  end

  assign led = led_q;
  assign out = out_q;

endmodule

// File: tb/tb_shortest_path_unit.sv
module tb_shortest_path_unit;
  import spa_pkg::*;

  logic       clock;
  logic       reset;
  logic [3:0] btn;
  logic [2:0] pts;
  logic       led;
  logic [2:0] out;

  int tests = 0;
  int fails = 0;

  shortest_path_unit #(.DEBOUNCE_CYCLES(2)) dut (
    .clock(clock),
    .reset(reset),
    .btn  (btn),
    .pts  (pts),
    .led  (led),
    .out  (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold long enough to be accepted, then let the release settle.
  task automatic press(input int b);
    btn[b] = 1'b1;
    repeat (3) @(negedge clock);
    btn[b] = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  task automatic set_nodes(input logic [2:0] s, input logic [2:0] d);
    btn[0] = 1'b0;
    repeat (6) @(negedge clock);
    pts = s;
    press(1);
    btn[0] = 1'b1;
    repeat (6) @(negedge clock);
    pts = d;
    press(1);
    btn[0] = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  task automatic wait_led(input string tag);
    int n;
    n = 0;
    while (!led && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_led"}, led, 1);
    chk({tag, "_lat"}, n <= 85, 1);
  endtask

  initial begin
    int cnt, first;
    reset = 1'b0;
    btn   = '0;
    pts   = '0;
    repeat (3) @(negedge clock);
    chk("rst_led", led, 0);
    chk("rst_out", out, 0);
    chk("rst_src", dut.src_q, 0);
    chk("rst_dst", dut.dst_q, 0);
    chk("rst_state", dut.state_q, ST_IDLE);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // 1-clock glitch on tk_inp: rejected, src not latched
    pts = 3'd5;
    cnt = 0;
    btn[1] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (c == 1) btn[1] = 1'b0;
      if (dut.tk_pulse) cnt++;
    end
    chk("glitch_pulses", cnt, 0);
    chk("glitch_src", dut.src_q, 0);

    // 2-clock press: single pulse, 4 clocks after the press
    pts = 3'd2;
    cnt = 0;
    first = -1;
    btn[1] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (c == 2) btn[1] = 1'b0;
      if (dut.tk_pulse) begin
        cnt++;
        if (first < 0) first = c;
      end
    end
    chk("min_press_pulses", cnt, 1);
    chk("min_press_latency", first, 4);
    chk("min_press_src", dut.src_q, 2);

    // Path 0 -> 7 : 0,1,2,7
    set_nodes(3'd0, 3'd7);
    chk("p07_src", dut.src_q, 0);
    chk("p07_dst", dut.dst_q, 7);
    press(3);
    chk("p07_idle", dut.state_q, ST_IDLE);
    press(2);
    wait_led("p07");
    chk("p07_out0", out, 0);
    press(2); chk("p07_out1", out, 1);
    press(2); chk("p07_out2", out, 2);
    press(2); chk("p07_out3", out, 7);
    press(2); chk("p07_sat", out, 7);
    chk("p07_led_hold", led, 1);

    // Mid-compute soft reset, then recompute the same path
    press(3);
    chk("mid_pre_idle", dut.state_q, ST_IDLE);
    press(2);
    chk("mid_busy", led, 0);
    press(3);
    chk("mid_led", led, 0);
    chk("mid_out", out, 0);
    chk("mid_state", dut.state_q, ST_IDLE);
    press(2);
    wait_led("mid_re");
    chk("mid_re_out0", out, 0);
    press(2); chk("mid_re_out1", out, 1);

    // New node entry does not disturb the displayed path
    set_nodes(3'd3, 3'd6);
    chk("p36_src", dut.src_q, 3);
    chk("p36_dst", dut.dst_q, 6);
    chk("p36_keep_out", out, 1);
    chk("p36_keep_led", led, 1);
    press(3);
    chk("p36_srst_led", led, 0);
    chk("p36_srst_out", out, 0);
    press(2);
    wait_led("p36");
    chk("p36_out0", out, 3);
    press(2); chk("p36_out1", out, 4);
    press(2); chk("p36_out2", out, 6);
    press(2); chk("p36_sat", out, 6);

    // src == dst
    set_nodes(3'd5, 3'd5);
    press(3);
    press(2);
    wait_led("p55");
    chk("p55_out0", out, 5);
    press(2); chk("p55_out1", out, 5);
    chk("p55_led", led, 1);

    // Async reset in STEP acts before any clock edge
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_out", out, 0);
    chk("arst_led", led, 0);
    chk("arst_src", dut.src_q, 0);
    chk("arst_dst", dut.dst_q, 0);
    chk("arst_state", dut.state_q, ST_IDLE);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
